// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Brief    : Decodes MIPS ALU-class instructions into operand/control bundles
//            and buffers them in a 2-entry issue FIFO for the ALU stage.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_con_Flush,
    input  logic        i_con_InValid,
    output logic        o_con_InReady,
    input  logic [31:0] i_data_Instr,
    input  logic [31:0] i_data_RsVal,
    input  logic [31:0] i_data_RtVal,
    input  logic [31:0] i_data_Pc,
    output logic        o_con_OutValid,
    input  logic        i_con_OutReady,
    output logic [31:0] o_data_A,
    output logic [31:0] o_data_B,
    output logic [3:0]  o_con_AluCtrl,
    output logic [4:0]  o_data_shamt,
    output logic [4:0]  o_data_WrReg,
    output logic        o_con_RegWrite,
    output logic        o_con_Illegal,
    output logic [15:0] o_data_IssueCnt
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;

    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_SRL  = 6'h02;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_ADDU = 6'h21;
    localparam logic [5:0] c_FN_SUB  = 6'h22;
    localparam logic [5:0] c_FN_SUBU = 6'h23;
    localparam logic [5:0] c_FN_AND  = 6'h24;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_XOR  = 6'h26;
    localparam logic [5:0] c_FN_NOR  = 6'h27;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;
    localparam logic [5:0] c_FN_SLTU = 6'h2B;

    localparam logic [3:0] c_ALU_AND = 4'd0;
    localparam logic [3:0] c_ALU_OR  = 4'd1;
    localparam logic [3:0] c_ALU_ADD = 4'd2;
    localparam logic [3:0] c_ALU_SLL = 4'd3;
    localparam logic [3:0] c_ALU_SRL = 4'd4;
    localparam logic [3:0] c_ALU_BNE = 4'd5;
    localparam logic [3:0] c_ALU_SUB = 4'd6;
    localparam logic [3:0] c_ALU_SLT = 4'd7;
    localparam logic [3:0] c_ALU_LUI = 4'd8;
    localparam logic [3:0] c_ALU_JAL = 4'd9;
    localparam logic [3:0] c_ALU_NOR = 4'd12;
    localparam logic [3:0] c_ALU_XOR = 4'd13;
    localparam logic [3:0] c_ALU_JR  = 4'd14;

    localparam logic [4:0] c_LINK_REG = 5'd31;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  wrreg;
        logic        regwrite;
    } entry_t;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sa;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic        w_unused_rs;
    logic        w_legal;
    entry_t      w_dec;

    assign w_op        = i_data_Instr[31:26];
    assign w_funct     = i_data_Instr[5:0];
    assign w_rt        = i_data_Instr[20:16];
    assign w_rd        = i_data_Instr[15:11];
    assign w_sa        = i_data_Instr[10:6];
    assign w_imm_sext  = {{16{i_data_Instr[15]}}, i_data_Instr[15:0]};
    assign w_imm_zext  = {16'h0000, i_data_Instr[15:0]};
    // The rs index is resolved upstream; only its value arrives here.
    assign w_unused_rs = ^i_data_Instr[25:21];

    always_comb begin
        w_legal        = 1'b1;
        w_dec          = '0;
        w_dec.a        = i_data_RsVal;
        w_dec.b        = i_data_RtVal;
        w_dec.wrreg    = w_rt;
        w_dec.regwrite = 1'b1;
        case (w_op)
            c_OP_RTYPE: begin
                w_dec.shamt = w_sa;
                w_dec.wrreg = w_rd;
                case (w_funct)
                    c_FN_AND:             w_dec.ctrl = c_ALU_AND;
                    c_FN_OR:              w_dec.ctrl = c_ALU_OR;
                    c_FN_ADD, c_FN_ADDU:  w_dec.ctrl = c_ALU_ADD;
                    c_FN_SLL:             w_dec.ctrl = c_ALU_SLL;
                    c_FN_SRL:             w_dec.ctrl = c_ALU_SRL;
                    c_FN_SUB, c_FN_SUBU:  w_dec.ctrl = c_ALU_SUB;
                    c_FN_SLT, c_FN_SLTU:  w_dec.ctrl = c_ALU_SLT;
                    c_FN_NOR:             w_dec.ctrl = c_ALU_NOR;
                    c_FN_XOR:             w_dec.ctrl = c_ALU_XOR;
                    c_FN_JR: begin
                        w_dec.ctrl     = c_ALU_JR;
                        w_dec.regwrite = 1'b0;
                    end
                    default:              w_legal = 1'b0;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU: begin
                w_dec.ctrl = c_ALU_ADD;
                w_dec.b    = w_imm_sext;
            end
            c_OP_SLTI, c_OP_SLTIU: begin
                w_dec.ctrl = c_ALU_SLT;
                w_dec.b    = w_imm_sext;
            end
            c_OP_ANDI: begin
                w_dec.ctrl = c_ALU_AND;
                w_dec.b    = w_imm_zext;
            end
            c_OP_ORI: begin
                w_dec.ctrl = c_ALU_OR;
                w_dec.b    = w_imm_zext;
            end
            c_OP_XORI: begin
                w_dec.ctrl = c_ALU_XOR;
                w_dec.b    = w_imm_zext;
            end
            c_OP_LUI: begin
                // The ALU performs the 16-bit shift; the raw immediate is issued.
                w_dec.ctrl = c_ALU_LUI;
                w_dec.b    = w_imm_zext;
            end
            c_OP_BEQ: begin
                w_dec.ctrl     = c_ALU_SUB;
                w_dec.wrreg    = 5'd0;
                w_dec.regwrite = 1'b0;
            end
            c_OP_BNE: begin
                w_dec.ctrl     = c_ALU_BNE;
                w_dec.wrreg    = 5'd0;
                w_dec.regwrite = 1'b0;
            end
            c_OP_JAL: begin
                w_dec.ctrl  = c_ALU_JAL;
                w_dec.a     = i_data_Pc;
                w_dec.b     = 32'h0000_0000;
                w_dec.wrreg = c_LINK_REG;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Two-entry issue FIFO
    // ------------------------------------------------------------------
    entry_t      r_mem_q [2];
    logic        r_wr_ptr_q;
    logic        r_rd_ptr_q;
    logic [1:0]  r_count_q;
    logic [1:0]  w_count_d;
    logic        r_illegal_q;
    logic [15:0] r_issue_cnt_q;
    logic        w_accept;
    logic        w_enq;
    logic        w_deq;
    entry_t      w_head;

    assign o_con_InReady  = (r_count_q < 2'd2);
    assign o_con_OutValid = (r_count_q != 2'd0);
    assign w_accept       = i_con_InValid & o_con_InReady & ~i_con_Flush;
    assign w_enq          = w_accept & w_legal;
    assign w_deq          = o_con_OutValid & i_con_OutReady;

    always_comb begin
        w_count_d = r_count_q;
        case ({w_enq, w_deq})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_q[0]    <= '0;
            r_mem_q[1]    <= '0;
            r_wr_ptr_q    <= 1'b0;
            r_rd_ptr_q    <= 1'b0;
            r_count_q     <= 2'd0;
            r_illegal_q   <= 1'b0;
            r_issue_cnt_q <= 16'h0000;
        end else begin
            r_illegal_q <= w_accept & ~w_legal;
            if (w_enq) begin
                r_issue_cnt_q <= r_issue_cnt_q + 16'd1;
            end
            if (i_con_Flush) begin
                r_wr_ptr_q <= 1'b0;
                r_rd_ptr_q <= 1'b0;
                r_count_q  <= 2'd0;
            end else begin
                if (w_enq) begin
                    r_mem_q[r_wr_ptr_q] <= w_dec;
                    r_wr_ptr_q          <= ~r_wr_ptr_q;
                end
                if (w_deq) begin
                    r_rd_ptr_q <= ~r_rd_ptr_q;
                end
                r_count_q <= w_count_d;
            end
        end
    end

    assign w_head          = r_mem_q[r_rd_ptr_q];
    assign o_data_A        = w_head.a;
    assign o_data_B        = w_head.b;
    assign o_con_AluCtrl   = w_head.ctrl;
    assign o_data_shamt    = w_head.shamt;
    assign o_data_WrReg    = w_head.wrreg;
    assign o_con_RegWrite  = w_head.regwrite;
    assign o_con_Illegal   = r_illegal_q;
    assign o_data_IssueCnt = r_issue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Brief    : Self-checking bench for alu_issue: decode table, directed FIFO
//            corner cases and a randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr, rsval, rtval, pc;
    logic        o_in_ready, o_out_valid, o_regwrite, o_illegal;
    logic [31:0] o_a, o_b;
    logic [3:0]  o_ctrl;
    logic [4:0]  o_shamt, o_wrreg;
    logic [15:0] o_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_con_Flush    (flush),
        .i_con_InValid  (in_valid),
        .o_con_InReady  (o_in_ready),
        .i_data_Instr   (instr),
        .i_data_RsVal   (rsval),
        .i_data_RtVal   (rtval),
        .i_data_Pc      (pc),
        .o_con_OutValid (o_out_valid),
        .i_con_OutReady (out_ready),
        .o_data_A       (o_a),
        .o_data_B       (o_b),
        .o_con_AluCtrl  (o_ctrl),
        .o_data_shamt   (o_shamt),
        .o_data_WrReg   (o_wrreg),
        .o_con_RegWrite (o_regwrite),
        .o_con_Illegal  (o_illegal),
        .o_data_IssueCnt(o_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  wrreg;
        bit          wrchk;
        bit          rw;
    } exp_t;

    exp_t        mq[$];
    logic [15:0] m_cnt = 16'h0000;
    bit          m_ill = 1'b0;

    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [31:0] pcv,
                              output bit lg, output exp_t e);
        logic [31:0] sx;
        logic [31:0] zx;
        sx      = {{16{ins[15]}}, ins[15:0]};
        zx      = {16'h0000, ins[15:0]};
        lg      = 1'b1;
        e.ctrl  = 4'd0;
        e.a     = rs;
        e.b     = rt;
        e.shamt = 5'd0;
        e.wrreg = ins[20:16];
        e.wrchk = 1'b1;
        e.rw    = 1'b1;
        case (ins[31:26])
            6'h00: begin
                e.shamt = ins[10:6];
                e.wrreg = ins[15:11];
                case (ins[5:0])
                    6'h24:        e.ctrl = 4'd0;
                    6'h25:        e.ctrl = 4'd1;
                    6'h20, 6'h21: e.ctrl = 4'd2;
                    6'h00:        e.ctrl = 4'd3;
                    6'h02:        e.ctrl = 4'd4;
                    6'h22, 6'h23: e.ctrl = 4'd6;
                    6'h2A, 6'h2B: e.ctrl = 4'd7;
                    6'h27:        e.ctrl = 4'd12;
                    6'h26:        e.ctrl = 4'd13;
                    6'h08: begin  e.ctrl = 4'd14; e.rw = 1'b0; end
                    default:      lg = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin e.ctrl = 4'd2;  e.b = sx; end
            6'h0A, 6'h0B: begin e.ctrl = 4'd7;  e.b = sx; end
            6'h0C:        begin e.ctrl = 4'd0;  e.b = zx; end
            6'h0D:        begin e.ctrl = 4'd1;  e.b = zx; end
            6'h0E:        begin e.ctrl = 4'd13; e.b = zx; end
            6'h0F:        begin e.ctrl = 4'd8;  e.b = zx; end
            6'h04:        begin e.ctrl = 4'd6;  e.rw = 1'b0; e.wrchk = 1'b0; end
            6'h05:        begin e.ctrl = 4'd5;  e.rw = 1'b0; e.wrchk = 1'b0; end
            6'h03:        begin e.ctrl = 4'd9;  e.a = pcv; e.b = 32'd0; e.wrreg = 5'd31; end
            default:      lg = 1'b0;
        endcase
    endtask

    task automatic model_edge();
        bit   acc;
        bit   lg;
        exp_t e;
        if (rst) begin
            mq.delete();
            m_cnt = 16'h0000;
            m_ill = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < 2) && !flush;
            ref_decode(instr, rsval, rtval, pc, lg, e);
            m_ill = acc && !lg;
            if (acc && lg) m_cnt = m_cnt + 16'd1;
            if (flush) begin
                mq.delete();
            end else begin
                if (out_ready && mq.size() > 0) void'(mq.pop_front());
                if (acc && lg) mq.push_back(e);
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic compare_all();
        chk("InReady",  32'(o_in_ready),  32'(mq.size() < 2));
        chk("OutValid", 32'(o_out_valid), 32'(mq.size() > 0));
        chk("Illegal",  32'(o_illegal),   32'(m_ill));
        chk("IssueCnt", 32'(o_cnt),       32'(m_cnt));
        if (mq.size() > 0) begin
            chk("head.ctrl",  32'(o_ctrl),     32'(mq[0].ctrl));
            chk("head.A",     o_a,             mq[0].a);
            chk("head.B",     o_b,             mq[0].b);
            chk("head.shamt", 32'(o_shamt),    32'(mq[0].shamt));
            chk("head.rw",    32'(o_regwrite), 32'(mq[0].rw));
            if (mq[0].wrchk) chk("head.WrReg", 32'(o_wrreg), 32'(mq[0].wrreg));
        end
    endtask

    task automatic cyc(input bit do_cmp);
        model_edge();
        @(posedge clk);
        #1;
        if (do_cmp) compare_all();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4 && mq.size() > 0; k++) cyc(1'b1);
        chk("drain.empty", 32'(o_out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".InReady"},  32'(o_in_ready),  32'd1);
        chk({tag, ".OutValid"}, 32'(o_out_valid), 32'd0);
        chk({tag, ".Illegal"},  32'(o_illegal),   32'd0);
        chk({tag, ".IssueCnt"}, 32'(o_cnt),       32'd0);
        chk({tag, ".A"},        o_a,              32'd0);
        chk({tag, ".B"},        o_b,              32'd0);
        chk({tag, ".ctrl"},     32'(o_ctrl),      32'd0);
        chk({tag, ".shamt"},    32'(o_shamt),     32'd0);
        chk({tag, ".WrReg"},    32'(o_wrreg),     32'd0);
        chk({tag, ".rw"},       32'(o_regwrite),  32'd0);
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [31:0] instr;
        bit          legal;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  wrreg;
        bit          wrchk;
        bit          rw;
    } vec_t;

    localparam logic [31:0] RS = 32'hA5A5_0001;
    localparam logic [31:0] RT = 32'h5A5A_0002;
    localparam logic [31:0] PC = 32'h0000_0400;

    vec_t vt[16];

    initial begin
        vt[0]  = '{32'h2425FFFF, 1, 4'd2,  RS, 32'hFFFFFFFF, 5'd0,  5'd5,  1, 1}; // addiu
        vt[1]  = '{32'h00021900, 1, 4'd3,  RS, RT,           5'd4,  5'd3,  1, 1}; // sll
        vt[2]  = '{32'h0C000100, 1, 4'd9,  PC, 32'h0,        5'd0,  5'd31, 1, 1}; // jal
        vt[3]  = '{32'h00223820, 1, 4'd2,  RS, RT,           5'd0,  5'd7,  1, 1}; // add
        vt[4]  = '{32'h03E00008, 1, 4'd14, RS, RT,           5'd0,  5'd0,  1, 0}; // jr
        vt[5]  = '{32'h28248000, 1, 4'd7,  RS, 32'hFFFF8000, 5'd0,  5'd4,  1, 1}; // slti
        vt[6]  = '{32'h34268001, 1, 4'd1,  RS, 32'h00008001, 5'd0,  5'd6,  1, 1}; // ori
        vt[7]  = '{32'h3826F0F0, 1, 4'd13, RS, 32'h0000F0F0, 5'd0,  5'd6,  1, 1}; // xori
        vt[8]  = '{32'h3C081234, 1, 4'd8,  RS, 32'h00001234, 5'd0,  5'd8,  1, 1}; // lui
        vt[9]  = '{32'h10220004, 1, 4'd6,  RS, RT,           5'd0,  5'd0,  0, 0}; // beq
        vt[10] = '{32'h14220004, 1, 4'd5,  RS, RT,           5'd0,  5'd0,  0, 0}; // bne
        vt[11] = '{32'h00224827, 1, 4'd12, RS, RT,           5'd0,  5'd9,  1, 1}; // nor
        vt[12] = '{32'hFC000000, 0, 4'd0,  RS, RT,           5'd0,  5'd0,  0, 0}; // op 0x3F
        vt[13] = '{32'h00000001, 0, 4'd0,  RS, RT,           5'd0,  5'd0,  0, 0}; // bad funct
        vt[14] = '{32'h00021FC2, 1, 4'd4,  RS, RT,           5'd31, 5'd3,  1, 1}; // srl
        vt[15] = '{32'h3026FFFF, 1, 4'd0,  RS, 32'h0000FFFF, 5'd0,  5'd6,  1, 1}; // andi
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'd0; rsval = RS; rtval = RT; pc = PC;
        #1;
        cyc(1'b0);
        cyc(1'b0);
        check_reset_outputs("reset");
        rst = 1'b0;

        // addiu rt=5, rs value 0x10, imm=0xFFFF
        rsval = 32'h10; instr = 32'h2425FFFF; in_valid = 1'b1;
        cyc(1'b1);
        in_valid = 1'b0;
        chk("addiu.OutValid", 32'(o_out_valid), 32'd1);
        chk("addiu.ctrl",     32'(o_ctrl),      32'd2);
        chk("addiu.B",        o_b,              32'hFFFFFFFF);
        chk("addiu.WrReg",    32'(o_wrreg),     32'd5);
        chk("addiu.rw",       32'(o_regwrite),  32'd1);
        chk("addiu.IssueCnt", 32'(o_cnt),       32'd1);
        rsval = RS;
        drain();

        // decode table, one instruction at a time into an empty FIFO
        for (int i = 0; i < 16; i++) begin
            drain();
            instr = vt[i].instr; in_valid = 1'b1; out_ready = 1'b0;
            cyc(1'b1);
            in_valid = 1'b0;
            chk($sformatf("v%0d.OutValid", i), 32'(o_out_valid), 32'(vt[i].legal));
            chk($sformatf("v%0d.Illegal", i),  32'(o_illegal),   32'(!vt[i].legal));
            if (vt[i].legal) begin
                chk($sformatf("v%0d.ctrl", i),  32'(o_ctrl),     32'(vt[i].ctrl));
                chk($sformatf("v%0d.A", i),     o_a,             vt[i].a);
                chk($sformatf("v%0d.B", i),     o_b,             vt[i].b);
                chk($sformatf("v%0d.shamt", i), 32'(o_shamt),    32'(vt[i].shamt));
                chk($sformatf("v%0d.rw", i),    32'(o_regwrite), 32'(vt[i].rw));
                if (vt[i].wrchk) chk($sformatf("v%0d.WrReg", i), 32'(o_wrreg), 32'(vt[i].wrreg));
            end
        end
        drain();

        // illegal pulse lasts one cycle, count unchanged
        instr = 32'hFC000000; in_valid = 1'b1;
        cyc(1'b1);
        in_valid = 1'b0;
        chk("ill.pulse", 32'(o_illegal), 32'd1);
        cyc(1'b1);
        chk("ill.gone",  32'(o_illegal), 32'd0);
        chk("ill.OutValid", 32'(o_out_valid), 32'd0);

        // backpressure: two fill, third held until a dequeue, order kept
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h24250001; cyc(1'b1);
        instr = 32'h24250002; cyc(1'b1);
        chk("bp.InReady_full", 32'(o_in_ready), 32'd0);
        instr = 32'h24250003; cyc(1'b1); cyc(1'b1);
        chk("bp.head_first", o_b, 32'd1);
        out_ready = 1'b1; cyc(1'b1);
        chk("bp.head_second", o_b, 32'd2);
        chk("bp.InReady_free", 32'(o_in_ready), 32'd1);
        out_ready = 1'b0; cyc(1'b1);
        chk("bp.third_taken", 32'(o_in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1; cyc(1'b1);
        chk("bp.head_third", o_b, 32'd3);

        // simultaneous enqueue and dequeue at count=1
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h24250005; cyc(1'b1);
        chk("sim.OutValid", 32'(o_out_valid), 32'd1);
        chk("sim.InReady",  32'(o_in_ready),  32'd1);
        chk("sim.head",     o_b,              32'd5);
        drain();

        // flush with a same-cycle offer at count=2
        in_valid = 1'b1; instr = 32'h24250007; cyc(1'b1); cyc(1'b1);
        flush = 1'b1; cyc(1'b1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.OutValid", 32'(o_out_valid), 32'd0);
        chk("flush.InReady",  32'(o_in_ready),  32'd1);
        cyc(1'b1);
        chk("flush.empty", 32'(o_out_valid), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 1) == 1);
            rsval     = $urandom;
            rtval     = $urandom;
            pc        = $urandom;
            if ($urandom_range(0, 3) == 0) instr = $urandom;
            else instr = vt[$urandom_range(0, 15)].instr;
            cyc(1'b1);
        end
        rst = 1'b0; flush = 1'b0; rsval = RS; rtval = RT; pc = PC;

        // issue counter wrap: 65535 enqueues from reset, then one more
        rst = 1'b1; cyc(1'b1); rst = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'h2425FFFF;
        for (int n = 0; n < 65535; n++) cyc(1'b0);
        compare_all();
        chk("wrap.at_max", 32'(o_cnt), 32'h0000FFFF);
        out_ready = 1'b0; cyc(1'b1);
        chk("wrap.to_zero", 32'(o_cnt), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1; cyc(1'b1);
        chk("wrap.count1", 32'(o_out_valid), 32'd1);

        // reset wins over flush, enqueue and dequeue
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cyc(1'b0);
        check_reset_outputs("rst_prio");
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cyc(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
